cp0_intc: RTL and testbench
===========================

CP0_INTC -- requirements
Module: cp0_intc

Interface
REQ-001 Parameter NUM_IRQ, default 4, number of external interrupt lines; legal range 1..16.
REQ-002 Parameter VEC_BASE, default 32'h00000000, vector address for synchronous exceptions.
REQ-003 Parameter IRQ_STRIDE, default 8, byte spacing of the interrupt vectors.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 RegReadAddr  in  5  CP0 register index for reads.
REQ-007 RegReadData  out  32  combinational read data.
REQ-008 RegWrite  in  1  register write strobe.
REQ-009 RegWriteAddr  in  5  register write index.
REQ-010 RegWriteData  in  32  register write data.
REQ-011 Irq  in  NUM_IRQ  level interrupt lines, synchronous to clk.
REQ-012 ExcValid  in  1  synchronous exception request, one cycle.
REQ-013 ExcCode  in  5  exception code accompanying ExcValid.
REQ-014 ExcPc  in  32  PC of the faulting or interrupted instruction.
REQ-015 Eret  in  1  return-from-exception strobe, one cycle.
REQ-016 Trap  out  1  registered one-cycle pulse: redirect fetch to TrapPc.
REQ-017 TrapPc  out  32  registered handler address, valid while Trap=1.
REQ-018 EpcOut  out  32  current epc value, used by the pipeline on Eret.

Function
REQ-019 Register 12 (status): bit0 IE (global interrupt enable), bit1 EXL (in handler), bit2 DF (sticky double fault), bits[8+NUM_IRQ-1:8] IM (per-line mask); all other bits read 0.
REQ-020 Register 13 (cause): bits[6:2] exccode, bits[8+NUM_IRQ-1:8] IP (pending), bits[31:27] index of the last interrupt taken; all other bits read 0.
REQ-021 Register 14 (epc): 32 bits, read/write.
REQ-022 Any other read address returns 0; writes to any other address are ignored.
REQ-023 Status writes update IE, EXL, DF and IM only.
REQ-024 Cause writes are write-1-to-clear on IP; exccode and the index field are not writable.
REQ-025 Irq is registered once (Irq_q); a 0->1 transition on line k sets IP[k] on the next edge.
REQ-026 When a rising edge on line k coincides with a write-1-to-clear of IP[k], the set wins.
REQ-027 Take condition: EXL=0 and (ExcValid=1, or IE=1 and |(IP & IM)).
REQ-028 Priority: ExcValid over interrupts; among interrupts, the lowest index wins.
REQ-029 On take (same edge):
- EXL <= 1; epc <= ExcPc.
- Exception: exccode <= ExcCode.
- Interrupt k: exccode <= 0, index <= k, IP[k] <= 0.
REQ-030 Trap is asserted on the cycle after the take edge, for exactly one cycle.
REQ-031 TrapPc is VEC_BASE for an exception and VEC_BASE + IRQ_STRIDE*(k+1) for interrupt k, computed modulo 2^32.
REQ-032 ExcValid while EXL=1 sets DF, causes no Trap, and leaves epc and cause unchanged.
REQ-033 Interrupts arriving while EXL=1 remain pending in IP.
REQ-034 Eret clears EXL on the next edge; EpcOut always equals epc.
REQ-035 A take and a RegWrite in the same cycle: the take updates status, cause and epc; the write is discarded for those registers.
REQ-036 Eret and a take condition in the same cycle: Eret has priority, EXL <= 0, no Trap that cycle; any pending interrupt is taken on a later cycle.
REQ-037 Two-state FSM, derived from EXL:
- NORMAL: EXL=0; take -> HANDLER.
- HANDLER: EXL=1; Eret -> NORMAL.
- Write of EXL: direct transition to the written state.

Reset
REQ-038 Asynchronous reset, effective immediately at any point, including mid-take:
- status, cause, epc, Irq_q <= 0.
- Trap <= 0; TrapPc <= 0.
REQ-039 After reset deassertion, a line already high does not set IP until it falls and rises again.

Verification
REQ-040 IE=1, IM=4'b0110; raise Irq[2] and Irq[1] together with ExcPc=32'h40 -> Trap one cycle later, TrapPc=32'h10, epc=32'h40, cause index=1, IP=4'b0100.
REQ-041 ExcValid with ExcCode=10, ExcPc=32'h80, IE=0 -> Trap, TrapPc=32'h0, exccode=10, EXL=1; a second ExcValid -> DF=1, no Trap, epc remains 32'h80.
REQ-042 EXL=1 with Irq[0] pending and IM[0]=IE=1; pulse Eret -> EXL=0 the next cycle, then Trap with TrapPc=32'h08.
REQ-043 RegWrite to epc of 32'hDEAD in the same cycle as an interrupt take with ExcPc=32'h20 -> epc=32'h20.
REQ-044 Assert rst during the Trap cycle -> Trap=0 immediately; all registers read 0.
REQ-045 Write cause=32'h00000100 while Irq[0] rises -> IP[0] stays 1; RegReadAddr=5 -> RegReadData=0.

Source files
------------

// File: rtl/cp0_intc.sv
// -----------------------------------------------------------------------------
// cp0_intc -- minimal CP0-style exception and interrupt controller.
//
// Holds the status (12), cause (13) and epc (14) registers, edge-detects the
// level interrupt lines into pending bits, and decides each cycle whether to
// take a synchronous exception or the lowest-numbered enabled interrupt. A take
// produces a registered one-cycle Trap pulse carrying the handler address.
//
// Ports
//   clk, rst       clock, asynchronous active-high reset
//   RegReadAddr    CP0 register index for the combinational read port
//   RegReadData    read data (0 for unimplemented indices)
//   RegWrite       write strobe, with RegWriteAddr / RegWriteData
//   Irq            level interrupt lines, synchronous to clk
//   ExcValid       one-cycle synchronous exception request, with ExcCode
//   ExcPc          PC saved into epc on any take
//   Eret           one-cycle return-from-exception strobe
//   Trap           one-cycle pulse: redirect fetch to TrapPc
//   TrapPc         handler address, valid while Trap is high
//   EpcOut         current epc value
// -----------------------------------------------------------------------------
module cp0_intc #(
    parameter int unsigned NUM_IRQ    = 4,
    parameter logic [31:0] VEC_BASE   = 32'h0000_0000,
    parameter int unsigned IRQ_STRIDE = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [4:0]         RegReadAddr,
    output logic [31:0]        RegReadData,
    input  logic               RegWrite,
    input  logic [4:0]         RegWriteAddr,
    input  logic [31:0]        RegWriteData,
    input  logic [NUM_IRQ-1:0] Irq,
    input  logic               ExcValid,
    input  logic [4:0]         ExcCode,
    input  logic [31:0]        ExcPc,
    input  logic               Eret,
    output logic               Trap,
    output logic [31:0]        TrapPc,
    output logic [31:0]        EpcOut
);

    localparam logic [4:0] ADDR_STATUS = 5'd12;
    localparam logic [4:0] ADDR_CAUSE  = 5'd13;
    localparam logic [4:0] ADDR_EPC    = 5'd14;

    // The FSM state register is the EXL bit itself.
    localparam logic [0:0] ST_NORMAL  = 1'b0;
    localparam logic [0:0] ST_HANDLER = 1'b1;

    logic [0:0]         state;
    logic [0:0]         state_next;
    logic               exl;
    logic               ie;
    logic               df;
    logic [NUM_IRQ-1:0] im;
    logic [NUM_IRQ-1:0] ip;
    logic [NUM_IRQ-1:0] ip_next;
    logic [NUM_IRQ-1:0] irq_q;
    logic               armed;
    logic [4:0]         exccode;
    logic [4:0]         irq_idx;
    logic [31:0]        epc;

    logic [NUM_IRQ-1:0] active;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] take_mask;
    logic               irq_any;
    logic [4:0]         irq_sel;
    logic [31:0]        irq_vec;
    logic               take_exc;
    logic               take_irq;
    logic               take;
    logic               wr_status;
    logic               wr_cause;
    logic               wr_epc;
    logic [31:0]        status_word;
    logic [31:0]        cause_word;

    assign exl    = (state == ST_HANDLER);
    assign EpcOut = epc;
    assign active = ip & im;

    // armed stays low for the first edge after reset so that a line already
    // high while in reset is captured into irq_q without looking like a rise.
    assign rise = armed ? (Irq & ~irq_q) : '0;

    // Lowest-index enabled pending interrupt.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        irq_any = 1'b0;
        irq_sel = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (active[i]) begin
                irq_any = 1'b1;
                irq_sel = 5'(i);
            end
        end
    end

    // Eret blocks any take in its cycle; a pending interrupt is taken later.
    assign take_exc = ~Eret & ~exl & ExcValid;
    assign take_irq = ~Eret & ~exl & ~ExcValid & ie & irq_any;
    assign take     = take_exc | take_irq;

    // Vector arithmetic wraps naturally at 32 bits.
    assign irq_vec   = VEC_BASE + 32'(IRQ_STRIDE) * (32'(irq_sel) + 32'd1);
    assign take_mask = take_irq ? (NUM_IRQ'(1) << irq_sel) : '0;

    // A take owns status, cause and epc for its cycle; a coincident write is dropped.
    assign wr_status = RegWrite & (RegWriteAddr == ADDR_STATUS) & ~take;
    assign wr_cause  = RegWrite & (RegWriteAddr == ADDR_CAUSE)  & ~take;
    assign wr_epc    = RegWrite & (RegWriteAddr == ADDR_EPC)    & ~take;

    // Pending bits: write-1-to-clear and take-clear first, new rising edges last
    // so that a coincident rise always wins.
    always_comb begin
        ip_next = ip;
        if (wr_cause) begin
            ip_next = ip_next & ~RegWriteData[8 +: NUM_IRQ];
        end
        ip_next = (ip_next & ~take_mask) | rise;
    end

    // Priority for EXL: software write < Eret < take.
    always_comb begin
        state_next = state;
        if (wr_status) begin
            state_next = RegWriteData[1] ? ST_HANDLER : ST_NORMAL;
        end
        case (state)
            ST_NORMAL: begin
                if (take) begin
                    state_next = ST_HANDLER;
                end else if (Eret) begin
                    state_next = ST_NORMAL;
                end
            end
            ST_HANDLER: begin
                if (Eret) begin
                    state_next = ST_NORMAL;
                end
            end
            default: state_next = ST_NORMAL;
        endcase
    end

    always_comb begin
        status_word               = '0;
        status_word[0]            = ie;
        status_word[1]            = exl;
        status_word[2]            = df;
        status_word[8 +: NUM_IRQ] = im;

        cause_word                = '0;
        cause_word[6:2]           = exccode;
        cause_word[8 +: NUM_IRQ]  = ip;
        cause_word[31:27]         = irq_idx;

        case (RegReadAddr)
            ADDR_STATUS: RegReadData = status_word;
            ADDR_CAUSE:  RegReadData = cause_word;
            ADDR_EPC:    RegReadData = epc;
            default:     RegReadData = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_NORMAL;
            ie      <= 1'b0;
            df      <= 1'b0;
            im      <= '0;
            ip      <= '0;
            irq_q   <= '0;
            armed   <= 1'b0;
            exccode <= '0;
            irq_idx <= '0;
            epc     <= '0;
            Trap    <= 1'b0;
            TrapPc  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state <= state_next;
            armed <= 1'b1;
            irq_q <= Irq;
            ip    <= ip_next;
            Trap  <= take;

            if (take) begin
                epc     <= ExcPc;
                TrapPc  <= take_exc ? VEC_BASE : irq_vec;
                exccode <= take_exc ? ExcCode : 5'd0;
                if (take_irq) begin
                    irq_idx <= irq_sel;
                end
            end else if (wr_epc) begin
                epc <= RegWriteData;
            end

            if (wr_status) begin
                ie <= RegWriteData[0];
                df <= RegWriteData[2];
                im <= RegWriteData[8 +: NUM_IRQ];
            end

            // Nested exception: flag it, leave epc/cause untouched, no Trap.
            if (ExcValid && exl) begin
                df <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cp0_intc.sv
// -----------------------------------------------------------------------------
// tb_cp0_intc -- self-checking bench for cp0_intc.
//
// A behavioural model tracks the architectural register contents; a compare
// process checks Trap, TrapPc, EpcOut and the read port against it on every
// falling edge. Directed scenarios add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_cp0_intc;

    localparam int          NUM_IRQ    = 4;
    localparam logic [31:0] VEC_BASE   = 32'h0000_0000;
    localparam int          IRQ_STRIDE = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic [4:0]         RegReadAddr;
    logic [31:0]        RegReadData;
    logic               RegWrite;
    logic [4:0]         RegWriteAddr;
    logic [31:0]        RegWriteData;
    logic [NUM_IRQ-1:0] Irq;
    logic               ExcValid;
    logic [4:0]         ExcCode;
    logic [31:0]        ExcPc;
    logic               Eret;
    logic               Trap;
    logic [31:0]        TrapPc;
    logic [31:0]        EpcOut;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    cp0_intc #(
        .NUM_IRQ    (NUM_IRQ),
        .VEC_BASE   (VEC_BASE),
        .IRQ_STRIDE (IRQ_STRIDE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .RegReadAddr  (RegReadAddr),
        .RegReadData  (RegReadData),
        .RegWrite     (RegWrite),
        .RegWriteAddr (RegWriteAddr),
        .RegWriteData (RegWriteData),
        .Irq          (Irq),
        .ExcValid     (ExcValid),
        .ExcCode      (ExcCode),
        .ExcPc        (ExcPc),
        .Eret         (Eret),
        .Trap         (Trap),
        .TrapPc       (TrapPc),
        .EpcOut       (EpcOut)
    );

    // ---------------------------------------------------------------- model
    bit                 m_ie, m_exl, m_df, m_trap;
    logic [NUM_IRQ-1:0] m_im, m_ip, m_prev;
    int                 m_code, m_idx;
    logic [31:0]        m_epc, m_tpc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Lines seen "high" at reset must fall before a rise counts, so the model
    // treats the previous sample as all ones after reset.
    task automatic model_reset();
        m_ie = 0; m_exl = 0; m_df = 0; m_trap = 0;
        m_im = '0; m_ip = '0; m_prev = '1;
        m_code = 0; m_idx = 0;
        m_epc = '0; m_tpc = '0;
    endtask

    task automatic model_step();
        logic [NUM_IRQ-1:0] rises;
        logic [NUM_IRQ-1:0] enabled;
        logic [NUM_IRQ-1:0] ip_n;
        int                 pend;
        bit                 go;
        bit                 was_exl;
        if (rst) begin
            model_reset();
            return;
        end
        rises   = Irq & ~m_prev;
        enabled = m_ip & m_im;
        pend    = -1;
        for (int i = NUM_IRQ - 1; i >= 0; i--) if (enabled[i]) pend = i;
        was_exl = m_exl;
        go      = !Eret && !m_exl && (ExcValid || (m_ie && pend >= 0));
        ip_n    = m_ip;
        m_prev  = Irq;
        m_trap  = go;
        if (go) begin
            m_exl = 1;
            m_epc = ExcPc;
            if (ExcValid) begin
                m_code = int'(ExcCode);
                m_tpc  = VEC_BASE;
            end else begin
                m_code     = 0;
                m_idx      = pend;
                ip_n[pend] = 1'b0;
                m_tpc      = VEC_BASE + 32'(IRQ_STRIDE * (pend + 1));
            end
        end else begin
            if (RegWrite && RegWriteAddr == 5'd12) begin
                m_ie  = RegWriteData[0];
                m_exl = RegWriteData[1];
                m_df  = RegWriteData[2];
                m_im  = RegWriteData[11:8];
            end
            if (RegWrite && RegWriteAddr == 5'd13) ip_n = ip_n & ~RegWriteData[11:8];
            if (RegWrite && RegWriteAddr == 5'd14) m_epc = RegWriteData;
            if (Eret) m_exl = 0;
        end
        if (ExcValid && was_exl) m_df = 1;
        m_ip = ip_n | rises;
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] a);
        case (a)
            5'd12:   return 32'(m_ie) | (32'(m_exl) << 1) | (32'(m_df) << 2) | (32'(m_im) << 8);
            5'd13:   return (32'(m_code) << 2) | (32'(m_ip) << 8) | (32'(m_idx) << 27);
            5'd14:   return m_epc;
            default: return 32'h0;
        endcase
    endfunction

    // ---------------------------------------------------------------- compare
    always @(negedge clk) begin
        check("trap", 32'(Trap), 32'(m_trap));
        check("epc_out", EpcOut, m_epc);
        check("read_data", RegReadData, model_read(RegReadAddr));
        if (m_trap) check("trap_pc", TrapPc, m_tpc);
    end

    // ---------------------------------------------------------------- driver
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        RegWrite = 1'b1; RegWriteAddr = a; RegWriteData = d;
        tick();
        RegWrite = 1'b0;
    endtask

    task automatic read_chk(input string name, input logic [4:0] a, input logic [31:0] exp);
        RegReadAddr = a;
        #1;
        check(name, RegReadData, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; RegReadAddr = 5'd12; RegWrite = 1'b0; RegWriteAddr = '0;
        RegWriteData = '0; Irq = '0; ExcValid = 1'b0; ExcCode = '0;
        ExcPc = '0; Eret = 1'b0;
        model_reset();
        tick(); tick();

        // Reset state
        read_chk("rst_status", 5'd12, 32'h0);
        read_chk("rst_cause", 5'd13, 32'h0);
        read_chk("rst_epc", 5'd14, 32'h0);
        check("rst_trap_pc", TrapPc, 32'h0);
        rst = 1'b0;
        tick();

        // Two lines rise together; lowest enabled index (1) wins.
        write_reg(5'd12, 32'h0000_0601);
        Irq = 4'b0110; ExcPc = 32'h40;
        tick();
        tick();
        check("irq_trap", 32'(Trap), 32'h1);
        check("irq_trap_pc", TrapPc, 32'h10);
        check("irq_epc", EpcOut, 32'h40);
        read_chk("irq_cause", 5'd13, 32'h0800_0400);
        read_chk("irq_status", 5'd12, 32'h0000_0603);
        tick();
        check("irq_trap_one_cycle", 32'(Trap), 32'h0);
        Irq = 4'b0000; Eret = 1'b1;
        tick();
        Eret = 1'b0;
        tick();
        check("irq2_trap_pc", TrapPc, 32'h18);
        read_chk("irq2_cause", 5'd13, 32'h1000_0000);
        Eret = 1'b1;
        tick();
        Eret = 1'b0;

        // Synchronous exception with IE=0, then a nested one.
        write_reg(5'd12, 32'h0);
        ExcValid = 1'b1; ExcCode = 5'd10; ExcPc = 32'h80;
        tick();
        ExcValid = 1'b0;
        check("exc_trap", 32'(Trap), 32'h1);
        check("exc_trap_pc", TrapPc, 32'h0);
        read_chk("exc_cause", 5'd13, 32'h1000_0028);
        read_chk("exc_status", 5'd12, 32'h0000_0002);
        tick();
        ExcValid = 1'b1; ExcCode = 5'd5; ExcPc = 32'h99;
        tick();
        ExcValid = 1'b0;
        check("df_no_trap", 32'(Trap), 32'h0);
        check("df_epc", EpcOut, 32'h80);
        read_chk("df_status", 5'd12, 32'h0000_0006);
        read_chk("df_cause", 5'd13, 32'h1000_0028);
        write_reg(5'd12, 32'h0);

        // Interrupt held pending under EXL, taken after Eret.
        write_reg(5'd12, 32'h0000_0103);
        Irq = 4'b0001;
        tick();
        tick();
        check("pend_no_trap", 32'(Trap), 32'h0);
        read_chk("pend_cause", 5'd13, 32'h1000_0128);
        Eret = 1'b1;
        tick();
        Eret = 1'b0;
        check("eret_no_trap", 32'(Trap), 32'h0);
        read_chk("eret_status", 5'd12, 32'h0000_0101);
        tick();
        check("eret_trap", 32'(Trap), 32'h1);
        check("eret_trap_pc", TrapPc, 32'h08);

        // epc write coinciding with an interrupt take is discarded.
        write_reg(5'd12, 32'h0000_0101);
        Irq = 4'b0000;
        tick();
        Irq = 4'b0001; ExcPc = 32'h20;
        tick();
        write_reg(5'd14, 32'h0000_DEAD);
        check("wr_take_trap", 32'(Trap), 32'h1);
        check("wr_take_epc", EpcOut, 32'h20);

        // Reset during the Trap cycle; lines held high through reset.
        rst = 1'b1; Irq = 4'b1001;
        model_reset();
        #1;
        check("rst_mid_trap", 32'(Trap), 32'h0);
        check("rst_mid_trap_pc", TrapPc, 32'h0);
        read_chk("rst_mid_status", 5'd12, 32'h0);
        read_chk("rst_mid_cause", 5'd13, 32'h0);
        read_chk("rst_mid_epc", 5'd14, 32'h0);
        tick(); tick();
        rst = 1'b0;
        write_reg(5'd12, 32'h0000_0F01);
        tick(); tick(); tick();
        read_chk("held_line_no_ip", 5'd13, 32'h0);
        Irq = 4'b0001;
        tick();
        Irq = 4'b1001;
        tick();
        tick();
        check("rearm_trap_pc", TrapPc, 32'h20);
        read_chk("rearm_cause", 5'd13, 32'h1800_0000);
        Eret = 1'b1;
        tick();
        Eret = 1'b0;

        // Coincident W1C and rising edge: the set wins.
        write_reg(5'd12, 32'h0000_0F00);
        Irq = 4'b1000;
        tick();
        Irq = 4'b1001;
        write_reg(5'd13, 32'h0000_0100);
        read_chk("w1c_vs_rise", 5'd13, 32'h1800_0100);
        read_chk("unmapped_read", 5'd5, 32'h0);
        write_reg(5'd13, 32'h0000_0100);
        read_chk("w1c_clear", 5'd13, 32'h1800_0000);
        write_reg(5'd5, 32'hFFFF_FFFF);
        read_chk("unmapped_write", 5'd12, 32'h0000_0F00);

        // Exception beats a simultaneously takeable interrupt.
        Irq = 4'b1000;
        tick();
        Irq = 4'b1001;
        write_reg(5'd12, 32'h0000_0F01);
        ExcValid = 1'b1; ExcCode = 5'd3; ExcPc = 32'h44;
        tick();
        ExcValid = 1'b0;
        check("exc_prio_trap_pc", TrapPc, 32'h0);
        read_chk("exc_prio_cause", 5'd13, 32'h1800_010C);
        RegReadAddr = 5'd13;
        Eret = 1'b1;
        tick();
        Eret = 1'b0;
        tick();
        check("after_prio_trap_pc", TrapPc, 32'h08);
        Eret = 1'b1;
        tick();
        Eret = 1'b0;
        tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
